neuron_mem_responder: RTL and testbench
=======================================

# neuron_mem_responder

Memory-side responder for the neuron controller's SRAM request interface. Holds the weight bank and input bank the controller reads from, and the result buffer it writes to. Returns registered read data one cycle after each read request and appends each write into a wrapping result buffer with occupancy tracking. A host preload port fills the banks, and a host readback port drains results.

## Interface
- ADDR_W, 4, address width of every bank; DEPTH = 2**ADDR_W entries per bank
- DATA_W, 8, width of weight and input words
- ACC_W, 2*DATA_W+ADDR_W, width of result words
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- read_enable  input  1  controller read request
- write_enable  input  1  controller write request
- weight_addr  input  ADDR_W  weight-bank read address (controller sram1 address)
- input_addr  input  ADDR_W  input-bank read address (controller sram2 address)
- write_data  input  ACC_W  result word to store
- load_en  input  1  host preload strobe
- load_sel  input  1  0 = weight bank, 1 = input bank
- load_addr  input  ADDR_W  preload address
- load_data  input  DATA_W  preload word
- rb_addr  input  ADDR_W  host result-readback address
- weight_data  output  DATA_W  registered weight read data
- input_data  output  DATA_W  registered input read data
- rvalid  output  1  read data valid, one-cycle pulse
- rb_data  output  ACC_W  registered result-buffer word at rb_addr
- result_count  output  ADDR_W+1  results stored, saturates at DEPTH
- overflow  output  1  sticky; a write arrived while the buffer was full

## Operation
- Three arrays: wmem[DEPTH] x DATA_W, imem[DEPTH] x DATA_W, rmem[DEPTH] x ACC_W. Array contents are not reset.
- Read: in a cycle with read_enable=1, both banks are read: weight_data <= wmem[weight_addr] and input_data <= imem[input_addr]. rvalid <= 1 on the same edge.
- In a cycle with read_enable=0, rvalid <= 0, and weight_data/input_data hold their last values.
- The controller issues a weight read and then an input read in back-to-back cycles. Each read is serviced independently, so rvalid is high for 2 consecutive cycles.
- Write: in a cycle with write_enable=1 and result_count < DEPTH:
  - rmem[wr_ptr] <= write_data
  - wr_ptr <= wr_ptr + 1, wrapping modulo DEPTH
  - result_count <= result_count + 1
- Write when full (result_count == DEPTH): the write is dropped, wr_ptr and result_count are unchanged, and overflow <= 1. overflow clears only on reset.
- Preload: in a cycle with load_en=1, mem[load_sel][load_addr] <= load_data.
- Preload and read in the same cycle, same bank and address: the read returns the old contents (read-before-write), and the new value is visible from the next cycle.
- read_enable and write_enable together: both are serviced, because they use separate banks.
- load_en is independent of the controller requests; all three may coincide.
- Readback: rb_data <= rmem[rb_addr] every cycle, giving 1-cycle latency. A write to rmem[rb_addr] in the same cycle returns the old word.
- Internal wr_ptr is ADDR_W bits wide, reset 0.

## Timing
- Reset values: weight_data=0, input_data=0, rvalid=0, rb_data=0, result_count=0, overflow=0, wr_ptr=0.
- Reset is asynchronous. Asserting it mid-sequence clears all the registers above immediately, and array contents are retained. The first request after deassertion behaves as from idle.
- Read latency is exactly 1 cycle, request edge to data. There are no wait states and no backpressure.
- Write-to-readback latency: a word written on edge N is visible on rb_data after edge N+1 (when rb_addr points to it).
- result_count is updated on the same edge as the write.
- overflow sets on the edge of the dropped write.

## Test plan
- Preload wmem[3]=0x12 and imem[3]=0x34. Apply read_enable for 2 cycles with weight_addr=3, input_addr=3. Required: rvalid high for exactly 2 cycles, weight_data=0x12, input_data=0x34.
- Same-cycle load and read of wmem[5]: wmem[5] is 0xAA, load writes 0x55 in the read cycle. Required: the read returns 0xAA, and a read on the next cycle returns 0x55.
- With ADDR_W=4, issue 16 writes of values 1..16. Required: result_count=16 and overflow=0. Issue a 17th write of 0x99. Required: overflow=1, result_count=16, and rmem[0] still 1 via rb_addr=0.
- Issue read_enable and write_enable in the same cycle. Required: rvalid=1 next cycle, and result_count increments by 1.
- Assert reset after 3 writes and a pending read. Required: rvalid=0, result_count=0, overflow=0, wr_ptr=0 immediately. The next write lands in rmem[0], and the preloaded wmem contents are unchanged.
- Readback latency: write 0x1234 on edge N with rb_addr=0 (the entry being written) held. Required: rb_data holds the old word after edge N, and rb_data=0x1234 after edge N+1.

Source files
------------

// File: rtl/neuron_mem_responder_if.sv
// Request/response bundle between the neuron controller (plus host port) and the
// memory responder holding the weight, input and result banks.
interface neuron_mem_responder_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 2 * DATA_W + ADDR_W
);
  logic              read_enable;
  logic              write_enable;
  logic [ADDR_W-1:0] weight_addr;
  logic [ADDR_W-1:0] input_addr;
  logic [ACC_W-1:0]  write_data;
  logic              load_en;
  logic              load_sel;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] weight_data;
  logic [DATA_W-1:0] input_data;
  logic              rvalid;
  logic [ACC_W-1:0]  rb_data;
  logic [ADDR_W:0]   result_count;
  logic              overflow;

  modport master (
    output read_enable, write_enable, weight_addr, input_addr, write_data,
           load_en, load_sel, load_addr, load_data, rb_addr,
    input  weight_data, input_data, rvalid, rb_data, result_count, overflow
  );

  modport slave (
    input  read_enable, write_enable, weight_addr, input_addr, write_data,
           load_en, load_sel, load_addr, load_data, rb_addr,
    output weight_data, input_data, rvalid, rb_data, result_count, overflow
  );
endinterface

// File: rtl/neuron_mem_responder.sv
// Memory-side responder: registered weight/input reads, wrapping result buffer
// with saturating occupancy and sticky overflow, host preload and readback.
module neuron_mem_responder #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 2 * DATA_W + ADDR_W
) (
  input logic                  clk,
  input logic                  reset,
  neuron_mem_responder_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_COUNT  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ONE_PTR    = ADDR_W'(1);

  logic [DATA_W-1:0] r_wmem [DEPTH];
  logic [DATA_W-1:0] r_imem [DEPTH];
  logic [ACC_W-1:0]  r_rmem [DEPTH];

  logic [DATA_W-1:0] r_weight_data;
  logic [DATA_W-1:0] r_input_data;
  logic              r_rvalid;
  logic [ACC_W-1:0]  r_rb_data;
  logic [ADDR_W:0]   r_result_count;
  logic              r_overflow;
  logic [ADDR_W-1:0] r_wr_ptr;

  logic w_full;
  logic w_accept;

  assign w_full   = (r_result_count == FULL_COUNT);
  assign w_accept = bus.write_enable && !w_full;

  // Array contents survive reset, so the storage lives in its own unreset block.
  always_ff @(posedge clk) begin
    if (bus.load_en) begin
      if (bus.load_sel) r_imem[bus.load_addr] <= bus.load_data;
      else              r_wmem[bus.load_addr] <= bus.load_data;
    end
    if (w_accept) r_rmem[r_wr_ptr] <= bus.write_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_weight_data  <= '0;
      r_input_data   <= '0;
      r_rvalid       <= 1'b0;
      r_rb_data      <= '0;
      r_result_count <= '0;
      r_overflow     <= 1'b0;
      r_wr_ptr       <= '0;
    end else begin
      r_rvalid  <= bus.read_enable;
      r_rb_data <= r_rmem[bus.rb_addr];
      if (bus.read_enable) begin
        r_weight_data <= r_wmem[bus.weight_addr];
        r_input_data  <= r_imem[bus.input_addr];
      end
      if (w_accept) begin
        r_wr_ptr       <= r_wr_ptr + ONE_PTR;
        r_result_count <= r_result_count + ONE_COUNT;
      end else if (bus.write_enable) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.weight_data  = r_weight_data;
  assign bus.input_data   = r_input_data;
  assign bus.rvalid       = r_rvalid;
  assign bus.rb_data      = r_rb_data;
  assign bus.result_count = r_result_count;
  assign bus.overflow     = r_overflow;
endmodule

// File: tb/tb_neuron_mem_responder.sv
// Scoreboarded bench for neuron_mem_responder: read responses are queued at issue
// and matched by a negedge monitor; buffer/reset behaviour is checked inline.
module tb_neuron_mem_responder;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 2 * DATA_W + ADDR_W;

  logic clk = 1'b0;
  logic reset;
  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] i;
    int unsigned       due;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;

  neuron_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  neuron_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.read_enable  = 1'b0;
    bus.write_enable = 1'b0;
    bus.weight_addr  = '0;
    bus.input_addr   = '0;
    bus.write_data   = '0;
    bus.load_en      = 1'b0;
    bus.load_sel     = 1'b0;
    bus.load_addr    = '0;
    bus.load_data    = '0;
  endtask

  task automatic load(input logic sel, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.load_en   = 1'b1;
    bus.load_sel  = sel;
    bus.load_addr = a;
    bus.load_data = d;
    step();
    bus.load_en = 1'b0;
  endtask

  task automatic push_read(input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] i);
    exp_t e;
    e.w   = w;
    e.i   = i;
    e.due = cyc + 1;
    q.push_back(e);
  endtask

  // Monitor: every rvalid must match the oldest queued read in the expected cycle.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        e_mon = q.pop_front();
        check("rvalid_missing", 32'd0, 32'd1);
      end
      if (bus.rvalid === 1'b1) begin
        if (q.size() == 0) begin
          check("rvalid_unexpected", 32'd1, 32'd0);
        end else begin
          e_mon = q.pop_front();
          check("rd_cycle", cyc, e_mon.due);
          check("weight_data", 32'(bus.weight_data), 32'(e_mon.w));
          check("input_data", 32'(bus.input_data), 32'(e_mon.i));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.rb_addr = '0;
    idle();
    step();
    step();
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_weight", 32'(bus.weight_data), 32'd0);
    check("rst_input", 32'(bus.input_data), 32'd0);
    check("rst_rb_data", 32'(bus.rb_data), 32'd0);
    check("rst_count", 32'(bus.result_count), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    reset = 1'b0;

    // Preload and a two-cycle read burst
    load(1'b0, 4'd3, 8'h12);
    load(1'b1, 4'd3, 8'h34);
    load(1'b0, 4'd5, 8'hAA);
    bus.read_enable = 1'b1;
    bus.weight_addr = 4'd3;
    bus.input_addr  = 4'd3;
    push_read(8'h12, 8'h34);
    step();
    push_read(8'h12, 8'h34);
    step();
    idle();
    step();
    step();

    // Same-cycle load and read of wmem[5]: old data first, new data next cycle
    bus.read_enable = 1'b1;
    bus.weight_addr = 4'd5;
    bus.input_addr  = 4'd3;
    bus.load_en     = 1'b1;
    bus.load_sel    = 1'b0;
    bus.load_addr   = 4'd5;
    bus.load_data   = 8'h55;
    push_read(8'hAA, 8'h34);
    step();
    bus.load_en = 1'b0;
    push_read(8'h55, 8'h34);
    step();
    idle();
    step();
    step();
    check("hold_weight", 32'(bus.weight_data), 32'h55);
    check("hold_rvalid", 32'(bus.rvalid), 32'd0);

    // Fill the result buffer, then overflow it
    for (int unsigned k = 1; k <= 16; k++) begin
      bus.write_enable = 1'b1;
      bus.write_data   = ACC_W'(k);
      step();
      if (k == 1) check("count_first", 32'(bus.result_count), 32'd1);
    end
    bus.write_enable = 1'b0;
    check("count_full", 32'(bus.result_count), 32'd16);
    check("no_overflow", 32'(bus.overflow), 32'd0);
    bus.write_enable = 1'b1;
    bus.write_data   = ACC_W'(32'h99);
    step();
    bus.write_enable = 1'b0;
    check("overflow_set", 32'(bus.overflow), 32'd1);
    check("count_sat", 32'(bus.result_count), 32'd16);
    bus.rb_addr = 4'd0;
    step();
    check("rb_entry0", 32'(bus.rb_data), 32'd1);
    bus.rb_addr = 4'd15;
    step();
    check("rb_entry15", 32'(bus.rb_data), 32'd16);
    check("overflow_sticky", 32'(bus.overflow), 32'd1);

    // Asynchronous reset clears state without a clock edge
    reset = 1'b1;
    #2;
    check("arst_count", 32'(bus.result_count), 32'd0);
    check("arst_overflow", 32'(bus.overflow), 32'd0);
    step();
    reset = 1'b0;

    // Three writes and an in-flight read, then reset before the read is seen
    for (int unsigned k = 0; k < 3; k++) begin
      bus.write_enable = 1'b1;
      bus.write_data   = ACC_W'(32'hA1 + k);
      step();
    end
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b1;
    bus.weight_addr  = 4'd3;
    bus.input_addr   = 4'd3;
    step();
    reset = 1'b1;
    #1;
    idle();
    check("prst_rvalid", 32'(bus.rvalid), 32'd0);
    check("prst_count", 32'(bus.result_count), 32'd0);
    check("prst_weight", 32'(bus.weight_data), 32'd0);
    step();
    reset = 1'b0;

    // First write after reset lands in rmem[0]
    bus.rb_addr      = 4'd0;
    bus.write_enable = 1'b1;
    bus.write_data   = ACC_W'(32'h77);
    step();
    bus.write_enable = 1'b0;
    check("post_rst_count", 32'(bus.result_count), 32'd1);
    step();
    check("post_rst_rb0", 32'(bus.rb_data), 32'h77);

    // Read and write together; wmem survived reset
    bus.read_enable  = 1'b1;
    bus.write_enable = 1'b1;
    bus.weight_addr  = 4'd3;
    bus.input_addr   = 4'd3;
    bus.write_data   = ACC_W'(32'h5);
    push_read(8'h12, 8'h34);
    step();
    idle();
    check("rw_rvalid", 32'(bus.rvalid), 32'd1);
    check("rw_count", 32'(bus.result_count), 32'd2);
    step();

    // Readback latency on the entry being written
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.rb_addr = 4'd0;
    step();
    check("rb_retained", 32'(bus.rb_data), 32'h77);
    bus.write_enable = 1'b1;
    bus.write_data   = ACC_W'(32'h1234);
    step();
    bus.write_enable = 1'b0;
    check("rb_old_word", 32'(bus.rb_data), 32'h77);
    step();
    check("rb_new_word", 32'(bus.rb_data), 32'h1234);

    step();
    step();
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
